// File: rtl/session_timeout_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : session_timeout_ctrl
//  Purpose  : ATM session sequencer (card insert, PIN, menu, transaction,
//             card eject) with one shared per-phase inactivity counter.
//  Revision : 1.0  initial release
// ============================================================================
module session_timeout_ctrl #(
   parameter int               CNT_W         = 32,
   parameter logic [CNT_W-1:0] T_PIN         = 32'd30000000,
   parameter logic [CNT_W-1:0] T_MENU        = 32'd30000000,
   parameter logic [CNT_W-1:0] T_TXN         = 32'd60000000,
   parameter logic [CNT_W-1:0] T_EJECT       = 32'd20000000,
   parameter int               MAX_PIN_TRIES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       card_in,
   input  logic       key_activity,
   input  logic       pin_enter,
   input  logic       pin_ok,
   input  logic       txn_sel,
   input  logic       txn_done,
   input  logic       cancel,
   output logic [2:0] state,
   output logic       session_active,
   output logic       eject_card,
   output logic       card_retain,
   output logic       timeout_pulse,
   output logic [1:0] pin_tries_left
);

   localparam logic [1:0] c_max_tries = MAX_PIN_TRIES[1:0];

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PIN   = 3'd1,
      S_MENU  = 3'd2,
      S_TXN   = 3'd3,
      S_EJECT = 3'd4
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_limit;
   logic             w_timeout;

   assign state = r_state;

   // Select the inactivity limit of the current phase; timeout fires on its last cycle.
   always_comb begin
      w_limit = T_PIN;
      case (r_state)
         S_PIN:   w_limit = T_PIN;
         S_MENU:  w_limit = T_MENU;
         S_TXN:   w_limit = T_TXN;
         S_EJECT: w_limit = T_EJECT;
         default: w_limit = T_PIN;
      endcase
      w_timeout = (r_state != S_IDLE) && (r_cnt == (w_limit - CNT_W'(1)));
   end

   // Session FSM: prioritised event handling, counter reload, registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         pin_tries_left <= c_max_tries;
         session_active <= 1'b0;
         eject_card     <= 1'b0;
         card_retain    <= 1'b0;
         timeout_pulse  <= 1'b0;
      end else begin
         card_retain   <= 1'b0;
         timeout_pulse <= 1'b0;
         r_cnt         <= r_cnt + CNT_W'(1);
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (card_in) begin
                  r_state        <= S_PIN;
                  pin_tries_left <= c_max_tries;
                  session_active <= 1'b1;
               end
            end
            S_PIN: begin
               if (!card_in) begin
                  r_state        <= S_IDLE;
                  r_cnt          <= '0;
                  session_active <= 1'b0;
               end else if (cancel) begin
                  r_state        <= S_EJECT;
                  r_cnt          <= '0;
                  session_active <= 1'b0;
                  eject_card     <= 1'b1;
               end else if (pin_enter) begin
                  r_cnt <= '0;
                  if (pin_ok) begin
                     r_state <= S_MENU;
                  end else begin
                     pin_tries_left <= pin_tries_left - 2'd1;
                     // Last attempt burned: the card is swallowed, no eject phase.
                     if (pin_tries_left == 2'd1) begin
                        r_state        <= S_IDLE;
                        session_active <= 1'b0;
                        card_retain    <= 1'b1;
                     end
                  end
               end else if (w_timeout) begin
                  r_state        <= S_EJECT;
                  r_cnt          <= '0;
                  session_active <= 1'b0;
                  eject_card     <= 1'b1;
                  timeout_pulse  <= 1'b1;
               end else if (key_activity) begin
                  r_cnt <= '0;
               end
            end
            S_MENU: begin
               if (!card_in) begin
                  r_state        <= S_IDLE;
                  r_cnt          <= '0;
                  session_active <= 1'b0;
               end else if (cancel) begin
                  r_state        <= S_EJECT;
                  r_cnt          <= '0;
                  session_active <= 1'b0;
                  eject_card     <= 1'b1;
               end else if (txn_sel) begin
                  r_state <= S_TXN;
                  r_cnt   <= '0;
               end else if (w_timeout) begin
                  r_state        <= S_EJECT;
                  r_cnt          <= '0;
                  session_active <= 1'b0;
                  eject_card     <= 1'b1;
                  timeout_pulse  <= 1'b1;
               end else if (key_activity) begin
                  r_cnt <= '0;
               end
            end
            S_TXN: begin
               // cancel is deliberately not decoded: the datapath runs to completion.
               if (!card_in) begin
                  r_state        <= S_IDLE;
                  r_cnt          <= '0;
                  session_active <= 1'b0;
               end else if (txn_done) begin
                  r_state <= S_MENU;
                  r_cnt   <= '0;
               end else if (w_timeout) begin
                  r_state        <= S_EJECT;
                  r_cnt          <= '0;
                  session_active <= 1'b0;
                  eject_card     <= 1'b1;
                  timeout_pulse  <= 1'b1;
               end
            end
            S_EJECT: begin
               if (!card_in) begin
                  r_state    <= S_IDLE;
                  r_cnt      <= '0;
                  eject_card <= 1'b0;
               end else if (w_timeout) begin
                  r_state       <= S_IDLE;
                  r_cnt         <= '0;
                  eject_card    <= 1'b0;
                  card_retain   <= 1'b1;
                  timeout_pulse <= 1'b1;
               end
            end
            default: begin
               r_state        <= S_IDLE;
               r_cnt          <= '0;
               session_active <= 1'b0;
               eject_card     <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/session_timeout_ctrl.md
Name: session_timeout_ctrl

Overview:
- ATM session sequencer: walks one customer session through card-insert, PIN entry, menu, transaction and card-eject phases.
- One shared cycle counter enforces a per-phase inactivity timeout. The counter is reloaded on every phase change and on qualifying key activity.
- Sits between the keypad/card-reader front end and the transaction datapath. Drives card eject/retain and reports timeouts to the display controller.

Parameters:
- CNT_W, 32, width of the shared timeout counter
- T_PIN, 32'd30000000, PIN-phase inactivity limit in clk cycles (>=2)
- T_MENU, 32'd30000000, MENU-phase inactivity limit (>=2)
- T_TXN, 32'd60000000, TXN-phase limit for datapath completion (>=2)
- T_EJECT, 32'd20000000, cycles allowed for card removal before retain (>=2)
- MAX_PIN_TRIES, 3, wrong-PIN attempts allowed (1..3)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- card_in  in  1  card present (level, synchronised upstream)
- key_activity  in  1  any keypress (1-cycle pulse)
- pin_enter  in  1  PIN submitted (1-cycle pulse)
- pin_ok  in  1  PIN verdict, valid with pin_enter
- txn_sel  in  1  transaction chosen (1-cycle pulse)
- txn_done  in  1  datapath finished the transaction (1-cycle pulse)
- cancel  in  1  cancel key (1-cycle pulse)
- state  out  3  IDLE=0, PIN=1, MENU=2, TXN=3, EJECT=4
- session_active  out  1  high in PIN, MENU and TXN
- eject_card  out  1  high while in EJECT
- card_retain  out  1  1-cycle pulse when the card is captured
- timeout_pulse  out  1  1-cycle pulse on any phase timeout
- pin_tries_left  out  2  remaining PIN attempts

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, pin_tries_left=MAX_PIN_TRIES, and every output pulse or level is 0. Reset mid-session aborts immediately, with no eject or retain pulse.
- All outputs are registered. State changes take effect on the clk edge following the qualifying input.
- Counter:
  - Cleared on every state change. Increments by 1 each cycle in PIN, MENU, TXN and EJECT. Held at 0 in IDLE.
  - Timeout condition: counter == T_x-1 for the current phase, so a phase with no qualifying events lasts exactly T_x cycles.
  - The counter never wraps, because a timeout always forces a state change.
- key_activity clears the counter in PIN and MENU only. It is ignored in TXN, EJECT and IDLE.
- Event priority within a cycle, highest first:
  1. card_in low (when not in IDLE or EJECT)
  2. cancel
  3. pin_enter / txn_sel / txn_done
  4. timeout
  5. key_activity
- Consequence of the priority order: an event coinciding with the timeout cycle wins, and timeout_pulse stays 0.
- IDLE: card_in=1 -> PIN. pin_tries_left is reloaded to MAX_PIN_TRIES.
- PIN:
  - pin_enter & pin_ok -> MENU.
  - pin_enter & !pin_ok: decrement pin_tries_left.
    - If it was 1: go to IDLE and pulse card_retain.
    - Otherwise stay in PIN with the counter cleared.
  - cancel -> EJECT.
  - timeout -> EJECT and pulse timeout_pulse.
- MENU:
  - txn_sel -> TXN.
  - cancel -> EJECT.
  - timeout -> EJECT and pulse timeout_pulse.
- TXN:
  - txn_done -> MENU (counter cleared).
  - cancel is ignored; the datapath must not be aborted.
  - timeout -> EJECT and pulse timeout_pulse.
- EJECT:
  - card_in=0 -> IDLE.
  - timeout (T_EJECT) -> IDLE and pulse card_retain, plus timeout_pulse in the same cycle.
- card_in dropping in PIN, MENU or TXN -> IDLE directly, with no pulses.
- Unused state encodings 5..7 -> IDLE on the next clk.
- pin_enter outside PIN, txn_sel outside MENU, and txn_done outside TXN are ignored.

Test Plan:
Bench parameters: T_PIN=10, T_MENU=8, T_TXN=12, T_EJECT=6, MAX_PIN_TRIES=3.
1. Happy path: card_in=1 -> state=1. pin_enter+pin_ok -> state=2. txn_sel -> 3. txn_done -> 2. cancel -> 4 with eject_card=1. card_in=0 -> state=0, session_active=0.
2. PIN timeout: card_in=1, no keys -> state is PIN for exactly 10 cycles, then state=4 with timeout_pulse high for 1 cycle. A key_activity at cycle 7 extends the PIN dwell to 7+10 cycles.
3. Wrong PIN x3: pin_enter with pin_ok=0 three times -> pin_tries_left goes 3->2->1, then state=0 with a single card_retain pulse. Two wrong PINs then a correct one -> MENU with pin_tries_left=1.
4. Eject unclaimed: enter EJECT, hold card_in=1 -> after 6 cycles state=0 with card_retain=1 and timeout_pulse=1 in the same cycle.
5. Collisions:
   - txn_done on the TXN timeout cycle (counter=11) -> MENU, timeout_pulse=0.
   - cancel in TXN -> state stays 3.
   - card_in=0 in MENU together with txn_sel -> IDLE.
6. Async reset: assert rst mid-TXN between clk edges -> state=0, pin_tries_left=3, all outputs 0 immediately. After release, the session restarts only on card_in=1.
